// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants, types and helpers for the seg7_scan display back-end.
//   NUM_DIGITS  : number of multiplexed digits
//   SEG_BLANK   : all segments off (active-low bus)
//   AN_OFF      : all anodes disabled (active-low enables)
//   ST_GUARD/ST_DRIVE : scan state encodings
//   frame_t     : one coherent frame of digit patterns and masks
//   digit_out() : resolves {seg, dp} for one digit of a frame
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  // Scan state: GUARD keeps every anode off while the bus settles on the new
  // digit, DRIVE enables exactly one anode.
  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][6:0] seg;    // active-low patterns, [0] = leftmost
    logic [NUM_DIGITS-1:0]      blank;  // force dark
    logic [NUM_DIGITS-1:0]      blink;  // dark during blink-off phase
    logic [NUM_DIGITS-1:0]      dp;     // decimal point lit (active-high here)
  } frame_t;

  localparam frame_t FRAME_RESET = '{
    seg:   {NUM_DIGITS{SEG_BLANK}},
    blank: '0,
    blink: '0,
    dp:    '0
  };

  // Returns {seg_out, dp_out} for digit i; dark digits drive everything off.
  function automatic logic [7:0] digit_out(input frame_t f,
                                           input logic [2:0] i,
                                           input logic blink_on);
    logic dark;
    dark = f.blank[i] | (f.blink[i] & ~blink_on);
    return dark ? {SEG_BLANK, 1'b1} : {f.seg[i], ~f.dp[i]};
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_if
// Bundle between the calendar/clock front-end and the display scanner.
//   seg7_0..seg7_7 : decoded digit patterns, active-low, digit 0 leftmost
//   blank_mask     : bit i forces digit i dark
//   blink_mask     : bit i blanks digit i during the blink-off phase
//   dp_mask        : bit i lights the decimal point of digit i
//   seg_out/dp_out : shared segment bus and decimal point, active-low
//   an_out         : anode enables, active-low, at most one low
//   frame_tick     : one-cycle pulse at each new frame
// Modports: master = front-end / bench, slave = seg7_scan.
// -----------------------------------------------------------------------------
interface seg7_scan_if;

  logic [6:0] seg7_0, seg7_1, seg7_2, seg7_3;
  logic [6:0] seg7_4, seg7_5, seg7_6, seg7_7;
  logic [7:0] blank_mask;
  logic [7:0] blink_mask;
  logic [7:0] dp_mask;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [7:0] an_out;
  logic       frame_tick;

  modport master (
    output seg7_0, seg7_1, seg7_2, seg7_3, seg7_4, seg7_5, seg7_6, seg7_7,
    output blank_mask, blink_mask, dp_mask,
    input  seg_out, dp_out, an_out, frame_tick
  );

  modport slave (
    input  seg7_0, seg7_1, seg7_2, seg7_3, seg7_4, seg7_5, seg7_6, seg7_7,
    input  blank_mask, blink_mask, dp_mask,
    output seg_out, dp_out, an_out, frame_tick
  );

endinterface

// File: rtl/seg7_scan_pulse_div.sv
// -----------------------------------------------------------------------------
// pulse_div
// Free-running counter 0..N-1 with a combinational pulse in the cycle the
// counter sits at N-1 (the cycle before it wraps to 0).
//   clk   : clock
//   rst_n : asynchronous active-low reset (counter -> 0)
//   pulse : high while count == N-1
// -----------------------------------------------------------------------------
module pulse_div #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pulse
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt;

  assign pulse = (cnt == W'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (pulse) cnt <= '0;
    else            cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Time-multiplexed 8-digit 7-segment driver with frame-coherent snapshot,
// anti-ghosting guard time, per-digit blanking, blink and decimal points.
//   clk_100MHz : system clock
//   reset      : asynchronous active-low reset
//   disp       : seg7_scan_if.slave (digit patterns and masks in; segment
//                bus, decimal point, anode enables and frame_tick out)
// -----------------------------------------------------------------------------
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 8000,
  parameter int GUARD_CYC = 64,
  parameter int BLINK_HZ  = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  seg7_scan_if.slave  disp
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int GW   = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  if (DIV < GUARD_CYC + 2) begin : g_bad_div
    $error("seg7_scan: DIV (%0d) must be at least GUARD_CYC+2 (%0d)", DIV, GUARD_CYC + 2);
  end
  if (GUARD_CYC < 1) begin : g_bad_guard
    $error("seg7_scan: GUARD_CYC must be at least 1");
  end

  logic          step;
  logic          blink_wrap;
  logic [2:0]    idx;
  logic [2:0]    idx_nxt;
  logic          wrap;
  logic [0:0]    state;
  logic [GW-1:0] guard_cnt;
  logic          blink_on;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          frame_tick_q;
  frame_t        snap;
  frame_t        live;
  frame_t        load_src;
  logic [7:0]    digit_nxt;

  pulse_div #(.N(DIV)) u_scan_div (
    .clk   (clk_100MHz),
    .rst_n (reset),
    .pulse (step)
  );

  pulse_div #(.N(HALF)) u_blink_div (
    .clk   (clk_100MHz),
    .rst_n (reset),
    .pulse (blink_wrap)
  );

  // NOTE: every signal written in always_comb gets a value on every path so no
  // latch is inferred.
  always_comb begin
    live       = FRAME_RESET;
    live.seg[0] = disp.seg7_0;
    live.seg[1] = disp.seg7_1;
    live.seg[2] = disp.seg7_2;
    live.seg[3] = disp.seg7_3;
    live.seg[4] = disp.seg7_4;
    live.seg[5] = disp.seg7_5;
    live.seg[6] = disp.seg7_6;
    live.seg[7] = disp.seg7_7;
    live.blank = disp.blank_mask;
    live.blink = disp.blink_mask;
    live.dp    = disp.dp_mask;

    idx_nxt  = idx + 3'd1;
    wrap     = (idx == 3'd7);
    // Digit 0 of a new frame is loaded on the same edge the snapshot is taken,
    // so it must come straight from the inputs being captured.
    load_src  = wrap ? live : snap;
    digit_nxt = digit_out(load_src, idx_nxt, blink_on);
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      idx          <= '0;
      state        <= ST_GUARD;
      guard_cnt    <= '0;
      blink_on     <= 1'b1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      // NOTE: the snapshot register is reset on purpose so the first frame
      // after reset is dark instead of showing power-up garbage.
      snap         <= FRAME_RESET;
    end else begin
      frame_tick_q <= step & wrap;
      if (blink_wrap) blink_on <= ~blink_on;

      if (step) begin
        idx       <= idx_nxt;
        state     <= ST_GUARD;
        guard_cnt <= '0;
        seg_q     <= digit_nxt[7:1];
        dp_q      <= digit_nxt[0];
        if (wrap) snap <= live;
      end else if (state == ST_GUARD) begin
        if (guard_cnt == GW'(GUARD_CYC - 1)) state     <= ST_DRIVE;
        else                                 guard_cnt <= guard_cnt + GW'(1);
      end
    end
  end

  // Anodes decode directly from the state flops, so reset forces them off
  // asynchronously and at most one bit can ever be low.
  assign disp.an_out     = (state == ST_DRIVE) ? ~(8'h01 << idx) : AN_OFF;
  assign disp.seg_out    = seg_q;
  assign disp.dp_out     = dp_q;
  assign disp.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan
// Self-checking bench for seg7_scan with DIV=8, GUARD_CYC=2, HALF=40.
// A driver applies per-cycle inputs and pushes the expected
// {frame_tick, dp_out, seg_out, an_out} for that cycle; a monitor pops and
// compares. Expected values come from cycle arithmetic since reset release.
// -----------------------------------------------------------------------------
module tb_seg7_scan;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  seg7_scan_if disp ();

  seg7_scan #(
    .CLK_HZ    (800),
    .SCAN_HZ   (100),
    .GUARD_CYC (2),
    .BLINK_HZ  (10)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .disp       (disp)
  );

  localparam logic [16:0] RST_VAL = {1'b0, 1'b1, 7'h7F, 8'hFF};

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit run2     = 1'b0;

  logic [16:0] exp_q[$];

  logic [6:0] m_seg[8];
  logic [7:0] m_blank, m_blink, m_dp;
  logic [6:0] in_seg[8];
  logic [7:0] in_blank, in_blink, in_dp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [16:0] obs();
    return {disp.frame_tick, disp.dp_out, disp.seg_out, disp.an_out};
  endfunction

  // Scenario inputs per cycle since reset release.
  task automatic drive_inputs(input int c);
    for (int i = 0; i < 8; i++) in_seg[i] = run2 ? 7'(8'h10 + i) : 7'(i);
    if (!run2 && c >= 522) in_seg[3] = 7'h55;   // mid-frame change at index 1
    in_blank = (!run2 && c >= 192 && c < 320) ? 8'h04 : 8'h00;
    in_blink = (!run2 && c >= 320) ? 8'h03 : 8'h00;
    in_dp    = (!run2 && c >= 320) ? 8'h81 : 8'h00;
    disp.seg7_0 = in_seg[0];
    disp.seg7_1 = in_seg[1];
    disp.seg7_2 = in_seg[2];
    disp.seg7_3 = in_seg[3];
    disp.seg7_4 = in_seg[4];
    disp.seg7_5 = in_seg[5];
    disp.seg7_6 = in_seg[6];
    disp.seg7_7 = in_seg[7];
    disp.blank_mask = in_blank;
    disp.blink_mask = in_blink;
    disp.dp_mask    = in_dp;
  endtask

  function automatic logic [16:0] expect_at(input int c);
    int pos, idx, s;
    logic [7:0] an;
    logic ft, d, on;
    logic [6:0] sg;
    pos = c % 8;
    idx = (c / 8) % 8;
    s   = c - pos;
    an  = (pos < 2) ? 8'hFF : ~(8'h01 << idx);
    ft  = (c >= 64) && (c % 64 == 0);
    if (s == 0) begin
      sg = 7'h7F;
      d  = 1'b1;
    end else begin
      on = (((s - 1) / 40) % 2) == 0;
      if (m_blank[idx] || (m_blink[idx] && !on)) begin
        sg = 7'h7F;
        d  = 1'b1;
      end else begin
        sg = m_seg[idx];
        d  = ~m_dp[idx];
      end
    end
    return {ft, d, sg, an};
  endfunction

  task automatic run_cycles(input int n, input int rst_at);
    for (int i = 0; i < 8; i++) m_seg[i] = 7'h7F;
    m_blank = '0;
    m_blink = '0;
    m_dp    = '0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      cyc = c;
      drive_inputs(c);
      exp_q.push_back(expect_at(c));
      if (c % 64 == 63) begin
        for (int i = 0; i < 8; i++) m_seg[i] = in_seg[i];
        m_blank = in_blank;
        m_blink = in_blink;
        m_dp    = in_dp;
      end
      if (c == rst_at) begin
        #5;
        reset = 1'b0;
        #1;
        check("async_reset", 32'(obs()), 32'(RST_VAL));
        repeat (2) begin
          @(negedge clk);
          #1;
          check("reset_hold2", 32'(obs()), 32'(RST_VAL));
        end
        @(negedge clk);
        reset = 1'b1;
        return;
      end
    end
    @(negedge clk);
    #5;
  endtask

  // Scoreboard monitor: compares one expected entry per cycle.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scan", 32'(obs()), 32'(e));
      end
    end
  end

  // Anodes must never enable two digits at once, reset edges included.
  always @(disp.an_out) begin
    if (!$isunknown(disp.an_out))
      check("an_onehot", 32'($countones(~disp.an_out) > 1), 32'(0));
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    drive_inputs(0);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset_hold", 32'(obs()), 32'(RST_VAL));
    end
    @(negedge clk);
    reset = 1'b1;
    // Frames 0-10; reset asserted in DRIVE on digit 5 of frame 10.
    run_cycles(700, 684);
    run2 = 1'b1;
    run_cycles(80, -1);
    if (exp_q.size() != 0) check("queue_drain", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
